// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
package vga_pkg;

  typedef logic [9:0] coord_t;

  // Field order fixes the bit layout carried through the sync delay line.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic active;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, active: 1'b0};

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_PIPE_LAT  = 1;

  function automatic int h_total(int visible, int front, int sync_w, int back);
    return visible + front + sync_w + back;
  endfunction

  function automatic int v_total(int visible, int front, int sync_w, int back);
    return visible + front + sync_w + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster outputs of the timing generator as seen by the color mapper.
// pix_ce marks the single Clk cycle at whose end DrawX/DrawY advance; no backpressure exists.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   pix_ce;
  logic   VGA_CLK;
  coord_t DrawX;
  coord_t DrawY;
  logic   VGA_HS;
  logic   VGA_VS;
  logic   VGA_BLANK_N;
  logic   frame_end;

  modport master (
    output pix_ce, VGA_CLK, DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N, frame_end
  );

  modport slave (
    input pix_ce, VGA_CLK, DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N, frame_end
  );

endinterface

// File: rtl/vga_sync_delay.sv
// Clock-enable gated shift register that realigns sync/blank with pipelined pixel data.
module vga_sync_delay #(
  parameter int             W       = 3,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    // Zero depth still shows the idle value while held in reset.
    logic run;
    logic unused_ce;

    assign unused_ce = ce;

    always_ff @(posedge clk) begin
      if (rst) run <= 1'b0;
      else     run <= 1'b1;
    end

    assign q = run ? d : RST_VAL;
  end else begin : g_shift
    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (ce) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel clock divider, h/v counters, sync/blank decode and frame tick.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int PIPE_LAT  = DEF_PIPE_LAT
) (
  input logic               Clk,
  input logic               Reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL  = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL  = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam coord_t           H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t           V_LAST   = coord_t'(V_TOTAL - 1);

  if (CLK_DIV < 1 || H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_LAT < 0 || PIPE_LAT > 3)
  begin : g_bad_params
    $error("vga_timing_gen: unsupported timing parameters");
  end

  logic [DIV_W-1:0] div;
  logic             pix_ce;
  logic             vga_clk;
  logic             clk_hi;
  coord_t           hc;
  coord_t           vc;
  sync_t            raw;
  sync_t            dly;

  // With no division the pixel clock level is simply held high.
  if (CLK_DIV == 1) begin : g_hi_one
    assign clk_hi = 1'b1;
  end else begin : g_hi_div
    assign clk_hi = (div >= DIV_HALF);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div     <= '0;
      pix_ce  <= 1'b0;
      vga_clk <= 1'b0;
    end else begin
      div     <= (div == DIV_LAST) ? '0 : div + 1'b1;
      pix_ce  <= (div == DIV_LAST);
      vga_clk <= clk_hi;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_ce) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  always_comb begin
    raw        = SYNC_IDLE;
    raw.active = (32'(hc) < H_VISIBLE) && (32'(vc) < V_VISIBLE);
    raw.hs_n   = !((32'(hc) >= HS_START) && (32'(hc) < HS_END));
    raw.vs_n   = !((32'(vc) >= VS_START) && (32'(vc) < VS_END));
  end

  vga_sync_delay #(
    .W       (3),
    .DEPTH   (PIPE_LAT),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk (Clk),
    .rst (Reset),
    .ce  (pix_ce),
    .d   (raw),
    .q   (dly)
  );

  assign vga.pix_ce      = pix_ce;
  assign vga.VGA_CLK     = vga_clk;
  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.VGA_HS      = dly.hs_n;
  assign vga.VGA_VS      = dly.vs_n;
  assign vga.VGA_BLANK_N = dly.active;
  // Combinational so the tick shares the edge on which the counters wrap to (0,0).
  assign vga.frame_end   = pix_ce && (hc == H_LAST) && (vc == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size line checks plus two shrunken-timing instances for frame-level behaviour.
module tb_vga_timing_gen;

  logic clk;
  logic rst_m;
  logic rst_s;
  logic rst_f;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  typedef struct {
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic blank;
  } vec_t;

  vec_t tab [12];

  vga_timing_gen_if vm ();
  vga_timing_gen_if vs ();
  vga_timing_gen_if vf ();

  vga_timing_gen u_main (.Clk(clk), .Reset(rst_m), .vga(vm));

  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .PIPE_LAT(1)
  ) u_small (.Clk(clk), .Reset(rst_s), .vga(vs));

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .PIPE_LAT(0)
  ) u_fast (.Clk(clk), .Reset(rst_f), .vga(vf));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [9:0] x, input logic [9:0] y, input logic ce,
                                     input logic vclk, input logic hs, input logic vsy,
                                     input logic bl, input logic fe);
    return {6'b0, x, y, ce, vclk, hs, vsy, bl, fe};
  endfunction

  logic [31:0] reset_vec;
  assign reset_vec = pk(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

  initial begin
    int hs_cnt, bl_cnt, ce_cnt, fe_cnt, vs_cnt;
    int fe_first, fe_second, vs_fall, budget;
    logic [19:0] vs_pos, fe_pos;

    tab[0]  = '{1,   0, 1'b1, 1'b1, 1'b1};
    tab[1]  = '{2,   0, 1'b1, 1'b1, 1'b1};
    tab[2]  = '{640, 0, 1'b1, 1'b1, 1'b1};
    tab[3]  = '{641, 0, 1'b1, 1'b1, 1'b0};
    tab[4]  = '{656, 0, 1'b1, 1'b1, 1'b0};
    tab[5]  = '{657, 0, 1'b0, 1'b1, 1'b0};
    tab[6]  = '{752, 0, 1'b0, 1'b1, 1'b0};
    tab[7]  = '{753, 0, 1'b1, 1'b1, 1'b0};
    tab[8]  = '{799, 0, 1'b1, 1'b1, 1'b0};
    tab[9]  = '{0,   1, 1'b1, 1'b1, 1'b0};
    tab[10] = '{1,   1, 1'b1, 1'b1, 1'b1};
    tab[11] = '{2,   1, 1'b1, 1'b1, 1'b1};

    rst_m = 1'b1;
    rst_s = 1'b1;
    rst_f = 1'b1;
    repeat (5) tick();
    check("m_reset", pk(vm.DrawX, vm.DrawY, vm.pix_ce, vm.VGA_CLK, vm.VGA_HS, vm.VGA_VS,
                        vm.VGA_BLANK_N, vm.frame_end), reset_vec);
    check("s_reset", pk(vs.DrawX, vs.DrawY, vs.pix_ce, vs.VGA_CLK, vs.VGA_HS, vs.VGA_VS,
                        vs.VGA_BLANK_N, vs.frame_end), reset_vec);
    check("f_reset", pk(vf.DrawX, vf.DrawY, vf.pix_ce, vf.VGA_CLK, vf.VGA_HS, vf.VGA_VS,
                        vf.VGA_BLANK_N, vf.frame_end), reset_vec);

    // Main instance: first strobe lands in the second cycle after release.
    rst_m = 1'b0;
    cyc = 0;
    tick();
    check("m_ce_cycle1", 32'(vm.pix_ce), 32'd0);
    tick();
    check("m_ce_cycle2", 32'({vm.pix_ce, vm.DrawX}), 32'({1'b1, 10'd0}));

    for (int i = 0; i < 12; i++) begin
      budget = 0;
      while (!(32'(vm.DrawX) == tab[i].x && 32'(vm.DrawY) == tab[i].y) && budget < 4000) begin
        tick();
        budget++;
      end
      check($sformatf("m_vec%0d_cyc", i), cyc, 2 * (tab[i].y * 800 + tab[i].x) + 1);
      check($sformatf("m_vec%0d_sync", i), 32'({vm.VGA_HS, vm.VGA_VS, vm.VGA_BLANK_N}),
            32'({tab[i].hs, tab[i].vs, tab[i].blank}));
      tick();
      check($sformatf("m_vec%0d_hold", i), 32'({vm.DrawX, vm.pix_ce}),
            32'({10'(tab[i].x), 1'b1}));
    end

    // One full line of strobes: sync width, visible width, no frame tick.
    hs_cnt = 0; bl_cnt = 0; ce_cnt = 0; fe_cnt = 0;
    repeat (1600) begin
      tick();
      if (vm.pix_ce) begin
        ce_cnt++;
        if (!vm.VGA_HS) hs_cnt++;
        if (vm.VGA_BLANK_N) bl_cnt++;
      end
      if (vm.frame_end) fe_cnt++;
    end
    check("m_line_ce", ce_cnt, 800);
    check("m_line_hs_low", hs_cnt, 96);
    check("m_line_visible", bl_cnt, 640);
    check("m_line_fe", fe_cnt, 0);

    // Small instance: frame tick period and vertical sync placement.
    rst_s = 1'b0;
    cyc = 0;
    fe_cnt = 0; vs_cnt = 0; fe_first = 0; fe_second = 0; vs_fall = 0;
    vs_pos = '0; fe_pos = '0;
    repeat (700) begin
      tick();
      if (vs.frame_end) begin
        fe_cnt++;
        if (fe_cnt == 1) begin
          fe_first = cyc;
          fe_pos = {vs.DrawX, vs.DrawY};
        end
        if (fe_cnt == 2) fe_second = cyc;
      end
      if (vs.pix_ce && !vs.VGA_VS && cyc <= 330) vs_cnt++;
      if (vs_fall == 0 && !vs.VGA_VS) begin
        vs_fall = cyc;
        vs_pos = {vs.DrawX, vs.DrawY};
      end
    end
    check("s_fe_count", fe_cnt, 2);
    check("s_fe_first", fe_first, 330);
    check("s_fe_period", fe_second - fe_first, 330);
    check("s_fe_pos", 32'(fe_pos), 32'({10'd14, 10'd10}));
    check("s_vs_low_pix", vs_cnt, 30);
    check("s_vs_fall_cyc", vs_fall, 213);
    check("s_vs_fall_pos", 32'(vs_pos), 32'({10'd1, 10'd7}));

    // Mid-frame reset at (5,4) restarts cleanly with no tick for the cut frame.
    budget = 0;
    while (!(vs.DrawX == 10'd5 && vs.DrawY == 10'd4) && budget < 400) begin
      tick();
      budget++;
    end
    check("s_pre_reset_pos", 32'({vs.DrawX, vs.DrawY, vs.VGA_BLANK_N}),
          32'({10'd5, 10'd4, 1'b1}));
    rst_s = 1'b1;
    tick();
    check("s_mid_reset", pk(vs.DrawX, vs.DrawY, vs.pix_ce, vs.VGA_CLK, vs.VGA_HS, vs.VGA_VS,
                            vs.VGA_BLANK_N, vs.frame_end), reset_vec);
    rst_s = 1'b0;
    cyc = 0;
    budget = 0;
    while (!vs.frame_end && budget < 1000) begin
      tick();
      budget++;
    end
    check("s_fe_after_reset", cyc, 330);

    // Fast instance: undivided clock, no delay, compared against a raster model every cycle.
    rst_f = 1'b0;
    cyc = 0;
    for (int c = 0; c <= 340; c++) begin
      logic [31:0] exp;
      int p, hc, vc;
      if (c > 0) tick();
      if (c == 0) begin
        exp = reset_vec;
      end else begin
        p  = c - 1;
        hc = p % 15;
        vc = (p / 15) % 11;
        exp = pk(10'(hc), 10'(vc), 1'b1, 1'b1, !(hc >= 10 && hc < 13), !(vc >= 7 && vc < 9),
                 (hc < 8 && vc < 6), (hc == 14 && vc == 10));
      end
      check($sformatf("f_cyc%0d", c), pk(vf.DrawX, vf.DrawY, vf.pix_ce, vf.VGA_CLK, vf.VGA_HS,
                                          vf.VGA_VS, vf.VGA_BLANK_N, vf.frame_end), exp);
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
